// File: rtl/multicycle_control_fsm_if.sv
// Datapath-facing bundle of the multi-cycle controller: opcode/memory handshake in, mux selects and strobes out.
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       RegDst;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               state, instr_done, illegal_op, bus_error
    );

    modport slave (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               state, instr_done, illegal_op, bus_error
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-32 control sequencer driving a shared-ALU/shared-memory datapath.
// Latency 2-5 cycles per instruction at zero wait; mem_ready low stalls FETCH/MEMRD/MEMWR, watchdog aborts to FETCH.
module multicycle_control_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam bit              WDOG_EN  = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             in_wait;
    logic             stall;
    logic             expire;
    ctrl_t            ctrl;
    ctrl_t            ctrl_gated;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Watchdog: counts consecutive not-ready cycles in a memory wait state.
    // A ready on the final counted cycle wins over expiry.
    always_comb begin
        in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        stall   = in_wait && !bus.mem_ready;
        expire  = WDOG_EN && stall && (cnt_q == CNT_LAST);
        cnt_d   = '0;
        if (WDOG_EN && stall && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
        bus_err_d = bus_err_q | expire;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        if (expire) state_d = S_FETCH;
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                ctrl.alu_src_b  = 2'b11;
                ctrl.illegal_op = !(bus.opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI});
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memto_reg  = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = bus.mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b10;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // Strobes must be quiet the instant reset asserts, not only after the next edge.
        ctrl_gated = rst_n ? ctrl : '0;
    end

    assign bus.PCWrite     = ctrl_gated.pc_write;
    assign bus.PCWriteCond = ctrl_gated.pc_write_cond;
    assign bus.IorD        = ctrl_gated.iord;
    assign bus.MemRead     = ctrl_gated.mem_read;
    assign bus.MemWrite    = ctrl_gated.mem_write;
    assign bus.MemtoReg    = ctrl_gated.memto_reg;
    assign bus.IRWrite     = ctrl_gated.ir_write;
    assign bus.PCSource    = ctrl_gated.pc_source;
    assign bus.ALUOp       = ctrl_gated.alu_op;
    assign bus.ALUSrcA     = ctrl_gated.alu_src_a;
    assign bus.ALUSrcB     = ctrl_gated.alu_src_b;
    assign bus.RegWrite    = ctrl_gated.reg_write;
    assign bus.RegDst      = ctrl_gated.reg_dst;
    assign bus.instr_done  = ctrl_gated.instr_done;
    assign bus.illegal_op  = ctrl_gated.illegal_op;
    assign bus.state       = state_q;
    assign bus.bus_error   = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction cycle plans are expanded into expected
// per-cycle observations, queued, and compared by an independent negedge monitor.
module tb_multicycle_control_fsm;

    localparam int TMO = 16;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mr, mw, m2r, irw;
        logic [1:0] pcs, aop;
        logic       srca;
        logic [1:0] srcb;
        logic       rw, rdst, done, ill, berr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    obs_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   exp_done = 0, exp_ill = 0, act_done = 0, act_ill = 0;
    bit   chk_on = 1'b0;
    logic berr_m = 1'b0;

    function automatic obs_t sample();
        obs_t a;
        a.st = bus.state;  a.pcw = bus.PCWrite;  a.pcwc = bus.PCWriteCond;  a.iord = bus.IorD;
        a.mr = bus.MemRead;  a.mw = bus.MemWrite;  a.m2r = bus.MemtoReg;  a.irw = bus.IRWrite;
        a.pcs = bus.PCSource;  a.aop = bus.ALUOp;  a.srca = bus.ALUSrcA;  a.srcb = bus.ALUSrcB;
        a.rw = bus.RegWrite;  a.rdst = bus.RegDst;  a.done = bus.instr_done;
        a.ill = bus.illegal_op;  a.berr = bus.bus_error;
        return a;
    endfunction

    // What the datapath should see in one cycle of a given phase of an instruction.
    function automatic obs_t exp_of(int st, bit rdy, logic [5:0] op, logic berr);
        obs_t e;
        e = '0;
        e.st = 4'(st);
        e.berr = berr;
        case (st)
            FETCH:  begin e.mr = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            DECODE: begin e.srcb = 2'b11; e.ill = !(op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW}); end
            MEMADR: begin e.srca = 1; e.srcb = 2'b10; end
            MEMRD:  begin e.mr = 1; e.iord = 1; end
            MEMWB:  begin e.m2r = 1; e.rw = 1; e.done = 1; end
            MEMWR:  begin e.mw = 1; e.iord = 1; e.done = rdy; end
            EXEC:   begin e.srca = 1; e.aop = 2'b10; end
            ALUWB:  begin e.rdst = 1; e.rw = 1; e.done = 1; end
            BRANCH: begin e.srca = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1; end
            JUMP:   begin e.pcw = 1; e.pcs = 2'b10; e.done = 1; end
            ADDIEX: begin e.srca = 1; e.srcb = 2'b10; end
            ADDIWB: begin e.rw = 1; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && sb.size() > 0) begin
            obs_t e, a;
            e = sb.pop_front();
            a = sample();
            check($sformatf("cycle(state %0d) t=%0t", e.st, $time), 64'(a), 64'(e));
        end
        if (chk_on && bus.instr_done) act_done++;
        if (chk_on && bus.illegal_op) act_ill++;
    end

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    // One clock cycle spent in phase st; entered and left at posedge+1.
    task automatic cyc(int st, bit rdy);
        obs_t e;
        bus.mem_ready = rdy;
        e = exp_of(st, rdy, bus.opcode, berr_m);
        if (e.done) exp_done++;
        if (e.ill) exp_ill++;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A memory phase that waits 'stalls' cycles; TMO consecutive stalls is a bus error.
    task automatic wait_phase(int st, int stalls, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i <= stalls; i++) begin
            if (i == stalls) begin
                cyc(st, 1'b1);
                return;
            end
            cyc(st, 1'b0);
            if (TMO > 0 && i == TMO - 1) begin
                berr_m  = 1'b1;
                aborted = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(logic [5:0] op, int fs, int ms);
        bit ab;
        bus.opcode = op;
        wait_phase(FETCH, fs, ab);
        if (ab) return;
        cyc(DECODE, rnd());
        case (op)
            OP_LW:   begin cyc(MEMADR, rnd()); wait_phase(MEMRD, ms, ab); if (!ab) cyc(MEMWB, rnd()); end
            OP_SW:   begin cyc(MEMADR, rnd()); wait_phase(MEMWR, ms, ab); end
            OP_R:    begin cyc(EXEC, rnd()); cyc(ALUWB, rnd()); end
            OP_BEQ:  cyc(BRANCH, rnd());
            OP_J:    cyc(JUMP, rnd());
            OP_ADDI: begin cyc(ADDIEX, rnd()); cyc(ADDIWB, rnd()); end
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops [8];
        ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI, 6'h3f, 6'h05};

        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = OP_R;
        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs_async", 64'(sample()), 64'(0));
        @(posedge clk);
        #1;
        check("reset_outputs_held", 64'(sample()), 64'(0));
        rst_n = 1'b1;
        chk_on = 1'b1;

        run_instr(OP_R, 0, 0);
        run_instr(OP_LW, 0, 2);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(6'h3f, 0, 0);
        run_instr(OP_ADDI, 1, 0);

        // Memory stuck in FETCH, then recovery with bus_error held.
        run_instr(OP_R, TMO, 0);
        run_instr(OP_R, 0, 0);

        for (int k = 0; k < 40; k++) begin
            run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3));
        end

        run_instr(OP_LW, 0, TMO - 1);
        run_instr(OP_LW, 0, TMO);
        run_instr(OP_SW, 2, TMO);
        run_instr(OP_SW, 0, TMO - 1);

        // Reset asserted in the middle of a stalled store.
        bus.opcode = OP_SW;
        cyc(FETCH, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(MEMADR, 1'b1);
        bus.mem_ready = 1'b0;
        sb.push_back(exp_of(MEMWR, 1'b0, OP_SW, berr_m));
        #6;
        rst_n = 1'b0;
        #1;
        check("reset_mid_memwr", 64'(sample()), 64'(0));
        @(posedge clk);
        #1;
        check("reset_mid_memwr_held", 64'(sample()), 64'(0));
        berr_m = 1'b0;
        rst_n = 1'b1;

        run_instr(OP_R, 0, 0);
        run_instr(OP_BEQ, 1, 0);

        @(negedge clk);
        #1;
        chk_on = 1'b0;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        check("instr_done_count", 64'(act_done), 64'(exp_done));
        check("illegal_op_count", 64'(act_ill), 64'(exp_ill));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
